// File: rtl/quad_decoder_pkg.sv
// Shared types and step classification for the quadrature step decoder.
package quad_decoder_pkg;

  typedef enum logic {INIT, RUN} state_t;

  typedef enum logic [1:0] {NONE, FWD, REV, ILLEGAL} step_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // prev/cur are {a, b}; forward order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic step_t classify_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = NONE;
    if (prev == cur) begin
      s = NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      s = ILLEGAL;
    end else begin
      case (prev)
        PH_00:   s = (cur == PH_01) ? FWD : REV;
        PH_01:   s = (cur == PH_11) ? FWD : REV;
        PH_11:   s = (cur == PH_10) ? FWD : REV;
        default: s = (cur == PH_00) ? FWD : REV;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/quad_phase_filter.sv
// One encoder phase: metastability synchroniser followed by a run-length de-glitch filter.
module quad_phase_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic load,
  output logic s,
  output logic filt
);
  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  // load forces the filtered level onto the synchronised input (used while the decoder initialises).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (load || (s == filt)) begin
      filt <= s;
      cnt  <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= s;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quadrature_step_decoder.sv
// Quadrature encoder front end: filtered phases, Gray-code step strobes and illegal-transition counting.
module quadrature_step_decoder
  import quad_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned ERR_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 en,
  input  logic                 clr_err,
  output logic                 up,
  output logic                 down,
  output logic                 dir,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 ready
);
  localparam int unsigned   IW        = $clog2(SYNC_STAGES + FILTER_LEN);
  localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES + FILTER_LEN - 1);

  state_t               state, state_nxt;
  logic [IW-1:0]        init_cnt, init_cnt_nxt;
  logic [1:0]           prev, prev_nxt, cur, sync_ab;
  logic                 s_a, s_b, filt_a, filt_b, load;
  logic                 up_nxt, down_nxt, dir_nxt, err_nxt, ready_nxt;
  logic [ERR_WIDTH-1:0] err_count_nxt;
  step_t                step;

  assign load    = (state == INIT);
  assign cur     = {filt_a, filt_b};
  assign sync_ab = {s_a, s_b};

  quad_phase_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk  (clk),
    .reset(reset),
    .raw  (enc_a),
    .load (load),
    .s    (s_a),
    .filt (filt_a)
  );

  quad_phase_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk  (clk),
    .reset(reset),
    .raw  (enc_b),
    .load (load),
    .s    (s_b),
    .filt (filt_b)
  );

  always_comb begin
    state_nxt     = state;
    init_cnt_nxt  = init_cnt;
    prev_nxt      = prev;
    up_nxt        = 1'b0;
    down_nxt      = 1'b0;
    err_nxt       = 1'b0;
    dir_nxt       = dir;
    ready_nxt     = ready;
    err_count_nxt = err_count;
    step          = classify_step(prev, cur);
    case (state)
      INIT: begin
        // Track the resting encoder position so leaving INIT never looks like a transition.
        prev_nxt     = sync_ab;
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == INIT_LAST) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end
      end
      default: begin
        prev_nxt = cur;
        if (en) begin
          case (step)
            FWD: begin
              up_nxt  = 1'b1;
              dir_nxt = 1'b1;
            end
            REV: begin
              down_nxt = 1'b1;
              dir_nxt  = 1'b0;
            end
            ILLEGAL: begin
              err_nxt = 1'b1;
              if (err_count != '1) err_count_nxt = err_count + 1'b1;
            end
            default: ;
          endcase
        end
      end
    endcase
    if (clr_err) err_count_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      prev      <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
      dir       <= 1'b0;
      err_pulse <= 1'b0;
      ready     <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      prev      <= prev_nxt;
      up        <= up_nxt;
      down      <= down_nxt;
      dir       <= dir_nxt;
      err_pulse <= err_nxt;
      ready     <= ready_nxt;
      err_count <= err_count_nxt;
    end
  end

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Directed bench for quadrature_step_decoder with a sample-window reference model.
module tb_quadrature_step_decoder;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int EW   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enc_a, enc_b, en, clr_err;
  logic          up, down, dir, err_pulse, ready;
  logic [EW-1:0] err_count;

  always #5 clk = ~clk;

  quadrature_step_decoder #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .ERR_WIDTH(EW)) dut (
    .clk      (clk),
    .reset    (reset),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .en       (en),
    .clr_err  (clr_err),
    .up       (up),
    .down     (down),
    .dir      (dir),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .ready    (ready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: filtered level flips once the last FILT synchronised samples all disagree with it.
  bit raw_a[$], raw_b[$], win_a[$], win_b[$];
  int m_edges = 0, m_errc = 0;
  bit m_fa = 0, m_fb = 0, m_up = 0, m_down = 0, m_dir = 0, m_errp = 0, m_ready = 0;
  bit [1:0] m_prev = 0;

  function automatic int pos(input bit [1:0] c);
    return int'({c[1], c[1] ^ c[0]});
  endfunction

  function automatic bit settled(input bit q[$], input bit f);
    if (q.size() != FILT) return 0;
    foreach (q[i]) if (q[i] == f) return 0;
    return 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit sa, sb;
    int st;
    if (!reset) begin
      raw_a.delete(); raw_b.delete(); win_a.delete(); win_b.delete();
      for (int i = 0; i < SYNC; i++) begin raw_a.push_back(0); raw_b.push_back(0); end
      m_edges = 0; m_errc = 0; m_fa = 0; m_fb = 0; m_prev = 0;
      m_up = 0; m_down = 0; m_dir = 0; m_errp = 0; m_ready = 0;
    end else begin
      sa = raw_a.pop_front(); sb = raw_b.pop_front();
      raw_a.push_back(enc_a); raw_b.push_back(enc_b);
      m_edges++;
      m_up = 0; m_down = 0; m_errp = 0;
      if (m_edges <= SYNC + FILT) begin
        m_fa = sa; m_fb = sb; m_prev = {sa, sb};
        win_a.delete(); win_b.delete();
        if (m_edges == SYNC + FILT) m_ready = 1;
      end else begin
        st = (pos({m_fa, m_fb}) - pos(m_prev) + 4) % 4;
        if (en) begin
          if (st == 1) begin m_up = 1; m_dir = 1; end
          if (st == 3) begin m_down = 1; m_dir = 0; end
          if (st == 2) begin m_errp = 1; if (m_errc < (1 << EW) - 1) m_errc++; end
        end
        m_prev = {m_fa, m_fb};
        win_a.push_back(sa); if (win_a.size() > FILT) void'(win_a.pop_front());
        win_b.push_back(sb); if (win_b.size() > FILT) void'(win_b.pop_front());
        if (settled(win_a, m_fa)) begin m_fa = sa; win_a.delete(); end
        if (settled(win_b, m_fb)) begin m_fb = sb; win_b.delete(); end
      end
      if (clr_err) m_errc = 0;
    end
  end

  int checks = 0, errors = 0;
  int n_up = 0, n_down = 0, n_err = 0;
  int up_cyc[$], down_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every waited cycle is compared against the model on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("up", int'(up), int'(m_up));
      chk("down", int'(down), int'(m_down));
      chk("dir", int'(dir), int'(m_dir));
      chk("err_pulse", int'(err_pulse), int'(m_errp));
      chk("err_count", int'(err_count), m_errc);
      chk("ready", int'(ready), int'(m_ready));
      chk("up_down_exclusive", int'(up & down), 0);
      if (up === 1'b1) begin n_up++; up_cyc.push_back(cyc); end
      if (down === 1'b1) begin n_down++; down_cyc.push_back(cyc); end
      if (err_pulse === 1'b1) n_err++;
      #1;
    end
  endtask

  task automatic drive(input bit [1:0] ab, input int hold);
    enc_a = ab[1]; enc_b = ab[0];
    tick(hold);
  endtask

  initial begin
    bit [1:0] seq[4];
    int chg[4];
    int bu, bd, be, bq;

    reset = 1'b0; enc_a = 1'b1; enc_b = 1'b1; en = 1'b1; clr_err = 1'b0;
    tick(3);
    reset = 1'b1;
    be = n_err;
    tick(5);
    chk("ready_before_6", int'(ready), 0);
    tick(1);
    chk("ready_at_6", int'(ready), 1);
    tick(4);
    chk("init_no_err_pulse", n_err - be, 0);
    chk("init_err_count", int'(err_count), 0);

    drive(2'b10, 20);
    drive(2'b00, 20);

    // Forward steps: each strobe lands 7 edges after the input change.
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    bu = n_up; bd = n_down; bq = up_cyc.size();
    for (int i = 0; i < 4; i++) begin
      chg[i] = cyc;
      drive(seq[i], 20);
    end
    chk("fwd_up_count", n_up - bu, 4);
    chk("fwd_down_count", n_down - bd, 0);
    chk("fwd_dir", int'(dir), 1);
    for (int i = 0; i < 4; i++)
      chk("fwd_latency", (up_cyc.size() > bq + i) ? up_cyc[bq + i] - chg[i] : -1, 7);

    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    bu = n_up; bd = n_down; bq = down_cyc.size();
    for (int i = 0; i < 4; i++) begin
      chg[i] = cyc;
      drive(seq[i], 20);
    end
    chk("rev_down_count", n_down - bd, 4);
    chk("rev_up_count", n_up - bu, 0);
    chk("rev_dir", int'(dir), 0);
    for (int i = 0; i < 4; i++)
      chk("rev_latency", (down_cyc.size() > bq + i) ? down_cyc[bq + i] - chg[i] : -1, 7);

    drive(2'b01, 20);
    bu = n_up; bd = n_down;
    drive(2'b11, 3);
    drive(2'b01, 20);
    chk("glitch3_up", n_up - bu, 0);
    chk("glitch3_down", n_down - bd, 0);
    drive(2'b11, 4);
    drive(2'b01, 20);
    chk("pulse4_up", n_up - bu, 1);
    chk("pulse4_down", n_down - bd, 1);
    chk("pulse4_spacing",
        (up_cyc.size() > 0 && down_cyc.size() > 0) ? down_cyc[$] - up_cyc[$] : -1, 4);

    drive(2'b00, 20);
    be = n_err; bu = n_up; bd = n_down;
    for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 2'b11 : 2'b00, 6);
    tick(10);
    chk("illegal_pulses", n_err - be, 300);
    chk("err_saturated", int'(err_count), 255);
    chk("illegal_no_steps", (n_up - bu) + (n_down - bd), 0);
    chk("illegal_dir_held", int'(dir), 0);

    be = n_err;
    drive(2'b11, 4);
    clr_err = 1'b1;
    tick(6);
    clr_err = 1'b0;
    tick(10);
    chk("clr_wins_pulse", n_err - be, 1);
    chk("clr_wins_count", int'(err_count), 0);
    drive(2'b00, 20);
    chk("count_after_clr", int'(err_count), 1);

    bu = n_up; bd = n_down; be = n_err;
    en = 1'b0;
    drive(2'b01, 20);
    drive(2'b11, 20);
    chk("en_off_dir_held", int'(dir), 0);
    en = 1'b1;
    tick(2);
    drive(2'b10, 20);
    chk("en_up_count", n_up - bu, 1);
    chk("en_down_count", n_down - bd, 0);
    chk("en_no_err", n_err - be, 0);
    chk("en_dir", int'(dir), 1);

    enc_a = 1'b0;
    tick(3);
    #3 reset = 1'b0;
    #1;
    chk("rst_up", int'(up), 0);
    chk("rst_down", int'(down), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_err_pulse", int'(err_pulse), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_ready", int'(ready), 0);
    tick(3);
    reset = 1'b1;
    bu = n_up; bd = n_down;
    tick(5);
    chk("reinit_ready_low", int'(ready), 0);
    tick(1);
    chk("reinit_ready_high", int'(ready), 1);
    tick(20);
    chk("reinit_no_steps", (n_up - bu) + (n_down - bd), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
